// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared types, constants and seven-segment encoder for the
//            traffic-light controller display blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX   = 4'd9;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Countdown control state: idle (display shows 0) or counting down.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } cd_state_t;

    // Active-low segments, bit order {dp, g, f, e, d, c, b, a}; dp always off.
    function automatic logic [7:0] seg_encode(input bcd_digit_t digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_display.sv
// ============================================================================
// Module   : digit_display
// Brief    : Registered BCD-to-seven-segment driver for one display digit,
//            with an optional blanking input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_display
    import traffic_pkg::*;
#(
    parameter bit RST_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  bcd_digit_t i_digit,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    logic [7:0] r_seg;

    // Reset value matches what the live path would show for a count of 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= RST_BLANK ? SEG_BLANK : seg_encode(4'd0);
        end else begin
            r_seg <= i_blank ? SEG_BLANK : seg_encode(i_digit);
        end
    end

    assign o_seg = r_seg;

endmodule

`default_nettype wire

// File: rtl/countdown_display.sv
// ============================================================================
// Module   : countdown_display
// Brief    : BCD seconds countdown with prescaler, expiry pulse and
//            seven-segment outputs. Option: COUNTDOWN_LEADING_ZERO_BLANK_EN
//            blanks digits above the most significant nonzero digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_display
    import traffic_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   remaining_bcd,
    output logic                  running,
    output logic                  expired,
    output logic [8*DIGITS-1:0]   seven_segment
);

    localparam int                 c_PRE_W   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLK_HZ - 1);
    localparam logic [4*DIGITS-1:0] c_ONE    = (4*DIGITS)'(1);

`ifdef COUNTDOWN_LEADING_ZERO_BLANK_EN
    localparam bit c_LZ_BLANK = 1'b1;
`else
    localparam bit c_LZ_BLANK = 1'b0;
`endif

    cd_state_t            r_state;
    cd_state_t            w_state_nxt;
    logic [c_PRE_W-1:0]   r_pre;
    logic [c_PRE_W-1:0]   w_pre_nxt;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [4*DIGITS-1:0]  w_bcd_nxt;
    logic                 r_expired;
    logic                 w_expired_nxt;

    logic [4*DIGITS-1:0]  w_bcd_clamped;
    logic [4*DIGITS-1:0]  w_bcd_dec;
    logic                 w_borrow;
    bcd_digit_t           w_dig;

    // Load clamp: any non-decimal nibble saturates to 9.
    always_comb begin
        w_bcd_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_bcd_clamped[4*i +: 4] = (load_bcd[4*i +: 4] > BCD_MAX) ? BCD_MAX
                                                                      : load_bcd[4*i +: 4];
        end
    end

    // BCD decrement with ripple borrow; only used when the count is nonzero.
    always_comb begin
        w_bcd_dec = '0;
        w_borrow  = 1'b1;
        w_dig     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = r_bcd[4*i +: 4];
            if (w_borrow) begin
                if (w_dig == 4'd0) begin
                    w_bcd_dec[4*i +: 4] = BCD_MAX;
                end else begin
                    w_bcd_dec[4*i +: 4] = w_dig - 4'd1;
                    w_borrow            = 1'b0;
                end
            end else begin
                w_bcd_dec[4*i +: 4] = w_dig;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pre_nxt     = r_pre;
        w_bcd_nxt     = r_bcd;
        w_expired_nxt = 1'b0;

        if (load) begin
            w_bcd_nxt   = w_bcd_clamped;
            w_pre_nxt   = c_PRE_MAX;
            w_state_nxt = (w_bcd_clamped != '0) ? ST_COUNT : ST_IDLE;
        end else begin
            case (r_state)
                ST_COUNT: begin
                    if (!pause) begin
                        if (r_pre == '0) begin
                            // Reload doubles as the hold value once the count expires.
                            w_pre_nxt = c_PRE_MAX;
                            w_bcd_nxt = w_bcd_dec;
                            if (r_bcd == c_ONE) begin
                                w_state_nxt   = ST_IDLE;
                                w_expired_nxt = 1'b1;
                            end
                        end else begin
                            w_pre_nxt = r_pre - c_PRE_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pre     <= c_PRE_MAX;
            r_bcd     <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_bcd     <= w_bcd_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    assign remaining_bcd = r_bcd;
    assign running       = (r_state == ST_COUNT);
    assign expired       = r_expired;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic w_blank;

        if (gi == 0) begin : g_lsd
            assign w_blank = 1'b0;
        end else begin : g_upper
`ifdef COUNTDOWN_LEADING_ZERO_BLANK_EN
            assign w_blank = (r_bcd[4*DIGITS-1:4*gi] == '0);
`else
            assign w_blank = 1'b0;
`endif
        end

        digit_display #(
            .RST_BLANK (c_LZ_BLANK && (gi != 0))
        ) u_digit (
            .clk     (clock),
            .rst     (reset),
            .i_digit (r_bcd[4*gi +: 4]),
            .i_blank (w_blank),
            .o_seg   (seven_segment[8*gi +: 8])
        );
    end

endmodule

`default_nettype wire
